// File: rtl/board_memory_pkg.sv
// Shared definitions for the chess board memory: piece codes, FSM states and
// the starting-layout generator used while the board is being (re)initialised.
package board_memory_pkg;

  localparam int BOARD_DIM  = 8;
  localparam int COLOUR_BIT = 3;

  localparam logic [2:0] P_EMPTY    = 3'd0;
  localparam logic [2:0] P_PAWN     = 3'd1;
  localparam logic [2:0] P_KNIGHT   = 3'd2;
  localparam logic [2:0] P_BISHOP   = 3'd3;
  localparam logic [2:0] P_ROOK     = 3'd4;
  localparam logic [2:0] P_QUEEN    = 3'd5;
  localparam logic [2:0] P_KING     = 3'd6;
  localparam logic [2:0] P_RESERVED = 3'd7;

  localparam logic C_WHITE = 1'b0;
  localparam logic C_BLACK = 1'b1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Cell index is {y, x}; back ranks mirror each other with the colour bit set for black.
  function automatic logic [3:0] start_piece(input logic [5:0] idx);
    logic [2:0] x_s;
    logic [2:0] y_s;
    logic [2:0] back_s;
    logic [3:0] piece_s;
    x_s = idx[2:0];
    y_s = idx[5:3];
    case (x_s)
      3'd0, 3'd7: back_s = P_ROOK;
      3'd1, 3'd6: back_s = P_KNIGHT;
      3'd2, 3'd5: back_s = P_BISHOP;
      3'd3:       back_s = P_QUEEN;
      3'd4:       back_s = P_KING;
      default:    back_s = P_EMPTY;
    endcase
    case (y_s)
      3'd0:    piece_s = {C_WHITE, back_s};
      3'd1:    piece_s = {C_WHITE, P_PAWN};
      3'd6:    piece_s = {C_BLACK, P_PAWN};
      3'd7:    piece_s = {C_BLACK, back_s};
      default: piece_s = {C_WHITE, P_EMPTY};
    endcase
    return piece_s;
  endfunction

endpackage

// File: rtl/board_memory_ram.sv
// Board storage: two synchronous write ports (a move commits destination and
// source together), a renderer read port with clear, and a source/destination read pair.
module board_memory_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  input  logic [ADDR_W-1:0] view_addr,
  input  logic              view_clr,
  output logic [WIDTH-1:0]  view_data,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [WIDTH-1:0]  src_data,
  output logic [WIDTH-1:0]  dst_data
);
  import board_memory_pkg::*;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] view_data_r;
  logic [WIDTH-1:0] src_data_r;
  logic [WIDTH-1:0] dst_data_r;

  // Storage writes; port a is applied last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem_r[addr_b] <= data_b;
    end
    if (we_a) begin
      mem_r[addr_a] <= data_a;
    end
  end

  // Registered reads (old data on a same-edge write); the renderer port can be forced to zero.
  always_ff @(posedge clk) begin
    view_data_r <= view_clr ? {WIDTH{1'b0}} : mem_r[view_addr];
    src_data_r  <= mem_r[src_addr];
    dst_data_r  <= mem_r[dst_addr];
  end

  assign view_data = view_data_r;
  assign src_data  = src_data_r;
  assign dst_data  = dst_data_r;

endmodule

// File: rtl/board_memory.sv
// Chess board memory: loads the starting layout after reset/new_game, serves
// renderer reads and executes single moves with capture reporting.
module board_memory #(
  parameter int BOARD_DIM = 8,
  parameter int PIECE_W   = 4,
  localparam int COORD_W  = $clog2(BOARD_DIM),
  localparam int ADDR_W   = 2 * COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] view_x,
  input  logic [COORD_W-1:0] view_y,
  output logic [PIECE_W-1:0] piece_read,
  input  logic               new_game,
  output logic               board_ready,
  input  logic               move_valid,
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  output logic               move_ready,
  output logic               move_done,
  output logic               move_err,
  output logic [PIECE_W-1:0] captured_piece
);
  import board_memory_pkg::*;

  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

  state_t             state_r;
  logic [ADDR_W-1:0]  count_r;
  logic [ADDR_W-1:0]  src_idx_r;
  logic [ADDR_W-1:0]  dst_idx_r;
  logic [PIECE_W-1:0] src_piece_r;
  logic [PIECE_W-1:0] dst_piece_r;
  logic [PIECE_W-1:0] captured_r;
  logic               board_ready_r;
  logic               move_done_r;
  logic               move_err_r;

  logic               same_cell_s;
  logic               do_move_s;
  logic               view_clr_s;
  logic               we_a_s;
  logic               we_b_s;
  logic [ADDR_W-1:0]  addr_a_s;
  logic [PIECE_W-1:0] data_a_s;
  logic [ADDR_W-1:0]  src_rd_addr_s;
  logic [ADDR_W-1:0]  dst_rd_addr_s;
  logic [PIECE_W-1:0] ram_src_s;
  logic [PIECE_W-1:0] ram_dst_s;

  assign same_cell_s = (src_idx_r == dst_idx_r);
  assign do_move_s   = (src_piece_r != {PIECE_W{1'b0}}) && !same_cell_s;

  // Renderer output is held at zero for every cycle spent in S_INIT, including the entry cycle.
  assign view_clr_s = reset || new_game || ((state_r == S_INIT) && (count_r != LAST_CELL));

  // In S_IDLE the move ports look at the live coordinates so S_READ already has the cell contents.
  assign src_rd_addr_s = (state_r == S_IDLE) ? {src_y, src_x} : src_idx_r;
  assign dst_rd_addr_s = (state_r == S_IDLE) ? {dst_y, dst_x} : dst_idx_r;

  // Storage write controls: layout fill during init, move commit in S_WRITE.
  always_comb begin
    we_a_s   = 1'b0;
    we_b_s   = 1'b0;
    addr_a_s = count_r;
    data_a_s = PIECE_W'(start_piece(count_r));
    if (reset || new_game) begin
      we_a_s = 1'b0;
    end else if (state_r == S_INIT) begin
      we_a_s = 1'b1;
    end else if ((state_r == S_WRITE) && do_move_s) begin
      we_a_s   = 1'b1;
      addr_a_s = dst_idx_r;
      data_a_s = src_piece_r;
      we_b_s   = 1'b1;
    end else begin
      we_a_s = 1'b0;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_INIT;
      count_r       <= {ADDR_W{1'b0}};
      src_idx_r     <= {ADDR_W{1'b0}};
      dst_idx_r     <= {ADDR_W{1'b0}};
      src_piece_r   <= {PIECE_W{1'b0}};
      dst_piece_r   <= {PIECE_W{1'b0}};
      captured_r    <= {PIECE_W{1'b0}};
      board_ready_r <= 1'b0;
      move_done_r   <= 1'b0;
      move_err_r    <= 1'b0;
    end else if (new_game) begin
      state_r       <= S_INIT;
      count_r       <= {ADDR_W{1'b0}};
      board_ready_r <= 1'b0;
      move_done_r   <= 1'b0;
    end else begin
      move_done_r <= 1'b0;
      case (state_r)
        S_INIT: begin
          count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (count_r == LAST_CELL) begin
            state_r       <= S_IDLE;
            board_ready_r <= 1'b1;
          end
        end
        S_IDLE: begin
          if (move_valid) begin
            src_idx_r     <= {src_y, src_x};
            dst_idx_r     <= {dst_y, dst_x};
            state_r       <= S_READ;
            board_ready_r <= 1'b0;
          end
        end
        S_READ: begin
          src_piece_r <= ram_src_s;
          dst_piece_r <= ram_dst_s;
          state_r     <= S_WRITE;
        end
        S_WRITE: begin
          move_done_r <= 1'b1;
          move_err_r  <= (src_piece_r == {PIECE_W{1'b0}});
          captured_r  <= same_cell_s ? {PIECE_W{1'b0}} : dst_piece_r;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          state_r       <= S_IDLE;
          board_ready_r <= 1'b1;
        end
        default: begin
          state_r       <= S_INIT;
          count_r       <= {ADDR_W{1'b0}};
          board_ready_r <= 1'b0;
        end
      endcase
    end
  end

  board_memory_ram #(
    .DEPTH(NUM_CELLS),
    .WIDTH(PIECE_W)
  ) u_ram (
    .clk      (clk),
    .we_a     (we_a_s),
    .addr_a   (addr_a_s),
    .data_a   (data_a_s),
    .we_b     (we_b_s),
    .addr_b   (src_idx_r),
    .data_b   ({PIECE_W{1'b0}}),
    .view_addr({view_y, view_x}),
    .view_clr (view_clr_s),
    .view_data(piece_read),
    .src_addr (src_rd_addr_s),
    .dst_addr (dst_rd_addr_s),
    .src_data (ram_src_s),
    .dst_data (ram_dst_s)
  );

  assign board_ready    = board_ready_r;
  assign move_ready     = board_ready_r;
  assign move_done      = move_done_r;
  assign move_err       = move_err_r;
  assign captured_piece = captured_r;

endmodule

// File: tb/tb_board_memory.sv
// Scoreboard bench for board_memory: moves push expected results, a negedge
// monitor pops them on move_done; a plain array models the board.
module tb_board_memory;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] view_x = 3'd0, view_y = 3'd0;
  logic [2:0] src_x = 3'd0, src_y = 3'd0, dst_x = 3'd0, dst_y = 3'd0;
  logic [3:0] piece_read, captured_piece;
  logic       board_ready, move_ready, move_done, move_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int board [64];

  typedef struct {
    int acc;
    int err;
    int cap;
  } exp_t;
  exp_t sbq [$];

  board_memory #(.BOARD_DIM(8), .PIECE_W(4)) dut (
    .clk(clk), .reset(reset),
    .view_x(view_x), .view_y(view_y), .piece_read(piece_read),
    .new_game(new_game), .board_ready(board_ready),
    .move_valid(move_valid),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .move_ready(move_ready), .move_done(move_done), .move_err(move_err),
    .captured_piece(captured_piece)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int layout(input int x, input int y);
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    case (y)
      0: return back[x];
      1: return 1;
      6: return 9;
      7: return back[x] + 8;
      default: return 0;
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 64; i++) board[i] = layout(i % 8, i / 8);
  endtask

  // Monitor: every move_done must match the oldest expected move.
  always @(negedge clk) begin
    exp_t e;
    if (move_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_move_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("move_latency", cyc - e.acc, 3);
        chk("move_err", int'(move_err), e.err);
        chk("captured_piece", int'(captured_piece), e.cap);
      end
    end
  end

  // Called at a negedge; piece_read is sampled one clock after the address.
  task automatic check_cell(input string name, input int x, input int y, input int exp);
    view_x = 3'(x);
    view_y = 3'(y);
    @(negedge clk);
    chk(name, int'(piece_read), exp);
  endtask

  task automatic scan_board(input string name);
    for (int i = 0; i < 64; i++) check_cell(name, i % 8, i / 8, board[i]);
  endtask

  // Called in the first S_INIT cycle; counts not-ready cycles.
  task automatic count_init(input string name);
    int n = 0;
    int nz = 0;
    while (board_ready == 1'b0 && n < 200) begin
      if (piece_read != 4'd0) nz++;
      view_x = 3'($urandom_range(7));
      view_y = 3'($urandom_range(7));
      n++;
      @(negedge clk);
    end
    chk({name, "_init_cycles"}, n, 64);
    chk({name, "_init_piece_read_zero"}, nz, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!move_ready) chk("move_ready_timeout", 0, 1);
  endtask

  task automatic do_move(input int sx, input int sy, input int dx, input int dy);
    int n = 0;
    int s, d;
    exp_t e;
    wait_ready();
    if (!move_ready) return;
    s = sy * 8 + sx;
    d = dy * 8 + dx;
    e.acc = cyc;
    e.err = (board[s] == 0) ? 1 : 0;
    e.cap = (s == d) ? 0 : board[d];
    if (board[s] != 0 && s != d) begin
      board[d] = board[s];
      board[s] = 0;
    end
    sbq.push_back(e);
    move_valid = 1'b1;
    src_x = 3'(sx); src_y = 3'(sy); dst_x = 3'(dx); dst_y = 3'(dy);
    @(negedge clk);
    chk("move_ready_busy", int'(move_ready), 0);
    // Requests while busy must be ignored.
    src_x = 3'($urandom_range(7)); dst_y = 3'($urandom_range(7));
    @(negedge clk);
    src_y = 3'($urandom_range(7)); dst_x = 3'($urandom_range(7));
    @(negedge clk);
    move_valid = 1'b0;
    while (sbq.size() != 0 && n < 10) begin
      n++;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      chk("move_done_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_piece_read", int'(piece_read), 0);
    chk("rst_board_ready", int'(board_ready), 0);
    chk("rst_move_ready", int'(move_ready), 0);
    chk("rst_move_done", int'(move_done), 0);
    chk("rst_move_err", int'(move_err), 0);
    chk("rst_captured", int'(captured_piece), 0);
    reset = 1'b0;
    count_init("power_on");
    reset_model();

    check_cell("layout_0_0", 0, 0, 4);
    check_cell("layout_4_0", 4, 0, 6);
    check_cell("layout_3_7", 3, 7, 13);
    check_cell("layout_5_6", 5, 6, 9);
    check_cell("layout_3_3", 3, 3, 0);

    do_move(4, 1, 4, 3);
    check_cell("pawn_src_cleared", 4, 1, 0);
    check_cell("pawn_dst_written", 4, 3, 1);

    do_move(0, 0, 0, 6);
    chk("capture_value", int'(captured_piece), 9);
    check_cell("capture_dst", 0, 6, 4);
    check_cell("capture_src", 0, 0, 0);

    do_move(3, 3, 3, 4);
    chk("empty_src_err", int'(move_err), 1);
    check_cell("empty_src_nochange_a", 3, 3, 0);
    check_cell("empty_src_nochange_b", 3, 4, 0);
    do_move(0, 1, 0, 1);
    chk("same_cell_err", int'(move_err), 0);
    chk("same_cell_capture", int'(captured_piece), 0);
    check_cell("same_cell_kept", 0, 1, 1);

    for (int i = 0; i < 40; i++) begin
      int sx, sy, dx, dy;
      sx = $urandom_range(7); sy = $urandom_range(7);
      if ($urandom_range(3) != 0) begin
        for (int k = 0; k < 20; k++) begin
          if (board[sy * 8 + sx] == 0) begin
            sx = $urandom_range(7); sy = $urandom_range(7);
          end
        end
      end
      dx = $urandom_range(7); dy = $urandom_range(7);
      if ($urandom_range(7) == 0) begin
        dx = sx; dy = sy;
      end
      do_move(sx, sy, dx, dy);
      check_cell("random_dst_read", dx, dy, board[dy * 8 + dx]);
    end
    scan_board("scan_after_random");

    // new_game while the move is in S_READ: move aborted, layout reloaded.
    wait_ready();
    move_valid = 1'b1;
    src_x = 3'd4; src_y = 3'd6; dst_x = 3'd4; dst_y = 3'd4;
    @(negedge clk);
    move_valid = 1'b0;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    count_init("abort_in_read");
    reset_model();
    scan_board("scan_after_abort");

    // new_game and move_valid together: new_game wins, move dropped.
    wait_ready();
    new_game = 1'b1;
    move_valid = 1'b1;
    src_x = 3'd4; src_y = 3'd1; dst_x = 3'd4; dst_y = 3'd3;
    @(negedge clk);
    new_game = 1'b0;
    move_valid = 1'b0;
    count_init("newgame_vs_move");
    check_cell("dropped_move_src", 4, 1, 1);
    check_cell("dropped_move_dst", 4, 3, 0);

    // Empty source onto an occupied cell leaves move_err and captured_piece nonzero.
    do_move(3, 3, 0, 1);
    chk("pre_reset_err", int'(move_err), 1);
    chk("pre_reset_capture", int'(captured_piece), 1);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midinit_piece_read", int'(piece_read), 0);
    chk("midinit_board_ready", int'(board_ready), 0);
    chk("midinit_move_ready", int'(move_ready), 0);
    chk("midinit_move_done", int'(move_done), 0);
    chk("midinit_move_err", int'(move_err), 0);
    chk("midinit_captured", int'(captured_piece), 0);
    count_init("midinit_reset");
    reset_model();
    check_cell("rerun_layout_7_7", 7, 7, 12);
    check_cell("rerun_layout_3_0", 3, 0, 5);
    do_move(6, 7, 5, 5);
    check_cell("post_rerun_move", 5, 5, 10);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
